// File: rtl/tlc_lane_queue_counter.sv
// Per-lane waiting-car counters for the traffic light controller: sensor edge adds,
// prescaled drain while green, ambulance drain-only mode, and a registered busiest-lane pick.
module tlc_lane_queue_counter #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 15,
  parameter int unsigned DRAIN_DIV = 3,
  parameter int unsigned LIDX_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    acl_en,
  input  logic                    clr,
  input  logic [LANES-1:0]        car_in,
  input  logic [LANES-1:0]        green,
  output logic [LANES*WIDTH-1:0]  count,
  output logic [LANES-1:0]        full,
  output logic [LANES-1:0]        empty,
  output logic [LANES-1:0]        ovf,
  output logic [LIDX_W-1:0]       busiest,
  output logic                    busiest_vld
);

  localparam int unsigned DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DRAIN_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MAX_COUNT);

  logic [LANES-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [LANES-1:0][DIV_W-1:0] div_q, div_d;
  logic [LANES-1:0]            ovf_q, ovf_d;
  logic [LANES-1:0]            car_q;
  logic [LANES-1:0]            run, dec_ev, inc, dec;
  logic [LIDX_W-1:0]           busiest_q, best_idx;
  logic                        busiest_vld_q;
  logic [WIDTH-1:0]            best_cnt;

  // Adds only count in normal mode; drains run in normal or ambulance mode.
  assign run = green & {LANES{en | acl_en}};
  assign inc = car_in & ~car_q & {LANES{en}};
  assign dec = dec_ev;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign dec_ev[g] = run[g] & (div_q[g] == DIV_LAST);
    assign full[g]   = (cnt_q[g] == CNT_MAX);
    assign empty[g]  = (cnt_q[g] == '0);
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    div_d = div_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
        div_d[i] = '0;
      end else begin
        if (run[i]) div_d[i] = dec_ev[i] ? '0 : div_q[i] + DIV_W'(1);
        else        div_d[i] = '0;
        // Simultaneous add and drain cancel, even at the floor or ceiling.
        if (inc[i] && !dec[i]) begin
          if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end else if (dec[i] && !inc[i] && (cnt_q[i] != '0)) begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end
      end
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (cnt_q[i] > best_cnt) begin
        best_cnt = cnt_q[i];
        best_idx = LIDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      div_q         <= '0;
      ovf_q         <= '0;
      car_q         <= '0;
      busiest_q     <= '0;
      busiest_vld_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      ovf_q         <= ovf_d;
      car_q         <= car_in;
      busiest_q     <= best_idx;
      busiest_vld_q <= |cnt_q;
    end
  end

  assign count       = cnt_q;
  assign ovf         = ovf_q;
  assign busiest     = busiest_q;
  assign busiest_vld = busiest_vld_q;

endmodule
